// File: rtl/div_result_ctrl.sv
// div_result_ctrl: issue/retire control around a pipelined divider with a credit-bounded result FIFO
// Optional flush port and kill logic are built in when DIV_CTRL_FLUSH_EN is defined.
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module div_result_ctrl #(
    parameter int DEPTH      = 20,
    parameter int TAG_W      = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic [1:0]            req_op,
    input  logic [TAG_W-1:0]      req_tag,
    input  logic [`SIZE_DATA-1:0] req_a,
    input  logic [`SIZE_DATA-1:0] req_b,
    output logic [`SIZE_DATA-1:0] div_a,
    output logic [`SIZE_DATA-1:0] div_b,
    output logic                  div_a_signed,
    output logic                  div_b_signed,
    input  logic [`SIZE_DATA-1:0] div_quo,
    input  logic [`SIZE_DATA-1:0] div_rem,
`ifdef DIV_CTRL_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  res_vld,
    input  logic                  res_rdy,
    output logic [`SIZE_DATA-1:0] res_data,
    output logic [TAG_W-1:0]      res_tag
);
    localparam int W  = `SIZE_DATA;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DEPTH-1:0]     v;
    logic [DEPTH-1:0]     sel;
    logic [TAG_W-1:0]     tag_pipe [DEPTH];
    logic [TAG_W+W-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [CW-1:0]        cnt;
    logic                 kill;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 empty;
    logic                 full;

`ifdef DIV_CTRL_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign div_a        = req_a;
    assign div_b        = req_b;
    assign div_a_signed = ~req_op[0];
    assign div_b_signed = ~req_op[0];

    // Credits come from the registered count only, so res_rdy never reaches req_rdy
    assign req_rdy = !kill && (cnt < CW'(FIFO_DEPTH));
    assign accept  = req_vld && req_rdy;
    assign push    = v[DEPTH-1];
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign res_vld = !empty;
    assign pop     = res_vld && res_rdy;
    assign {res_tag, res_data} = mem[rd_ptr[AW-1:0]];

    // Valid bits track ops through the divider; a flush drops everything in flight
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            v <= '0;
        end else begin
            v[0] <= accept;
            for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1];
        end
    end

    // Tag and quotient/remainder select ride alongside the valid bits
    always_ff @(posedge clk) begin
        tag_pipe[0] <= req_tag;
        sel[0]      <= req_op[1];
        for (int i = 1; i < DEPTH; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
            sel[i]      <= sel[i-1];
        end
    end

    // Result storage; head entry drives the result outputs directly
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (push && !kill) begin
            mem[wr_ptr[AW-1:0]] <= {tag_pipe[DEPTH-1], sel[DEPTH-1] ? div_rem : div_quo};
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end

    // Outstanding ops: in the divider pipe plus waiting in the FIFO
    always_ff @(posedge clk) begin
        if (rst || kill) cnt <= '0;
        else cnt <= cnt + CW'(accept) - CW'(pop);
    end

    // A push into a full FIFO would mean the credit accounting is broken
    always_ff @(posedge clk) begin
        if (!rst && !kill) assert (!(push && full));
    end
endmodule

// File: tb/tb_div_result_ctrl.sv
// tb_div_result_ctrl: scoreboard bench for div_result_ctrl with a behavioural pipelined divider
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_div_result_ctrl;
    localparam int DEPTH = 20;
    localparam int TAG_W = 7;
    localparam int FD    = 4;
    localparam int W     = `SIZE_DATA;
    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_vld = 1'b0;
    logic               req_rdy;
    logic [1:0]         req_op = 2'd0;
    logic [TAG_W-1:0]   req_tag = '0;
    logic [W-1:0]       req_a = '0;
    logic [W-1:0]       req_b = '0;
    logic [W-1:0]       div_a;
    logic [W-1:0]       div_b;
    logic               div_a_signed;
    logic               div_b_signed;
    logic [W-1:0]       div_quo;
    logic [W-1:0]       div_rem;
`ifdef DIV_CTRL_FLUSH_EN
    logic               flush = 1'b0;
`endif
    logic               res_vld;
    logic               res_rdy = 1'b0;
    logic [W-1:0]       res_data;
    logic [TAG_W-1:0]   res_tag;

    int compared = 0;
    int mismatched = 0;
    logic [TAG_W+W-1:0] exp_q [$];
    logic [TAG_W+W-1:0] e;
    logic [2*W-1:0]     dpipe [DEPTH];

    always #5 clk = ~clk;

    div_result_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op), .req_tag(req_tag),
        .req_a(req_a), .req_b(req_b),
        .div_a(div_a), .div_b(div_b), .div_a_signed(div_a_signed), .div_b_signed(div_b_signed),
        .div_quo(div_quo), .div_rem(div_rem),
`ifdef DIV_CTRL_FLUSH_EN
        .flush(flush),
`endif
        .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data), .res_tag(res_tag)
    );

    function automatic logic [2*W-1:0] divf(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s && a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            q = a;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    // Behavioural divider: result appears DEPTH cycles after the operands
    always @(posedge clk) begin
        for (int i = DEPTH - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        dpipe[0] <= divf(div_a, div_b, div_a_signed & div_b_signed);
    end
    assign {div_quo, div_rem} = dpipe[DEPTH-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every result handshake is checked against the oldest expectation
    always @(negedge clk) begin
        if (!rst && res_vld && res_rdy) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got tag %0d data %0h, required no result", res_tag, res_data);
            end else begin
                e = exp_q.pop_front();
                chk("res_tag", 64'(res_tag), 64'(e[TAG_W+W-1:W]));
                chk("res_data", 64'(res_data), 64'(e[W-1:0]));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge
    task automatic issue(input logic [1:0] op, input int tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_d, input bit track = 1'b1);
        int n = 0;
        req_vld = 1'b1;
        req_op  = op;
        req_tag = TAG_W'(tag);
        req_a   = a;
        req_b   = b;
        if (track) exp_q.push_back({TAG_W'(tag), exp_d});
        @(negedge clk);
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) begin
            compared++;
            mismatched++;
            $display("FAIL issue_timeout: tag %0d req_rdy %0b, required 1", tag, req_rdy);
        end else begin
            @(posedge clk);
            #1;
        end
        req_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res_vld(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_vld && n < 100);
        chk(name, 64'(res_vld), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_rdy", 64'(req_rdy), 64'(1));
        chk("rst_res_vld", 64'(res_vld), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        chk("rst_res_tag", 64'(res_tag), 64'(0));
        @(posedge clk);
        #1;
        res_rdy = 1'b1;

        issue(DIVU, 5, 32'd100, 32'd7, 32'd14);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_vld && n < 100);
        chk("latency", 64'(n), 64'(DEPTH + 1));
        drain();

        issue(REM,  6,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);
        issue(DIV,  7,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD);
        issue(DIV,  8,  32'd9,         32'd0,        32'hFFFF_FFFF);
        issue(REMU, 9,  32'd9,         32'd0,        32'd9);
        issue(DIV,  10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue(REM,  11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        issue(DIVU, 12, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF);
        issue(REMU, 13, 32'd100,       32'd7,        32'd2);
        issue(REM,  14, 32'd7,         32'hFFFF_FFFE, 32'd1);
        issue(DIV,  15, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
        issue(REM,  16, 32'd9,         32'd0,        32'd9);
        drain();

        res_rdy = 1'b0;
        issue(DIVU, 20, 32'd60, 32'd3, 32'd20);
        issue(DIVU, 21, 32'd63, 32'd3, 32'd21);
        issue(DIVU, 22, 32'd66, 32'd3, 32'd22);
        @(negedge clk);
        chk("rdy_after_3rd", 64'(req_rdy), 64'(1));
        @(posedge clk);
        #1;
        issue(DIVU, 23, 32'd69, 32'd3, 32'd23);
        @(negedge clk);
        chk("rdy_after_4th", 64'(req_rdy), 64'(0));
        @(posedge clk);
        #1;
        req_vld = 1'b1;
        req_op  = DIVU;
        req_tag = TAG_W'(24);
        req_a   = 32'd72;
        req_b   = 32'd3;
        exp_q.push_back({TAG_W'(24), W'(24)});
        repeat (DEPTH + 4) @(negedge clk);
        chk("full_rdy_low", 64'(req_rdy), 64'(0));
        chk("full_res_vld", 64'(res_vld), 64'(1));
        chk("full_head_tag", 64'(res_tag), 64'(20));
        @(posedge clk);
        #1;
        res_rdy = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_rdy && n < 20);
        chk("rdy_reassert", 64'(n), 64'(2));
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        issue(DIVU, 25, 32'd75, 32'd3, 32'd25);
        drain();

        issue(DIV,  30, 32'd20,   32'd4,  32'd5);
        issue(REM,  31, 32'd20,   32'd6,  32'd2);
        issue(DIVU, 32, 32'd1000, 32'd10, 32'd100);
        issue(REMU, 33, 32'd1000, 32'd7,  32'd6);
        wait_res_vld("b2b_first");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b2b_no_gap", 64'(res_vld), 64'(1));
        end
        @(negedge clk);
        chk("b2b_end", 64'(res_vld), 64'(0));
        drain();

`ifdef DIV_CTRL_FLUSH_EN
        res_rdy = 1'b0;
        issue(DIVU, 40, 32'd1, 32'd1, 32'd1, 1'b0);
        wait_res_vld("flush_buffered");
        @(posedge clk);
        #1;
        issue(DIVU, 41, 32'd1, 32'd1, 32'd1, 1'b0);
        issue(DIVU, 42, 32'd1, 32'd1, 32'd1, 1'b0);
        issue(DIVU, 43, 32'd1, 32'd1, 32'd1, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rdy", 64'(req_rdy), 64'(0));
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_res_vld", 64'(res_vld), 64'(0));
        chk("flush_rdy_back", 64'(req_rdy), 64'(1));
        res_rdy = 1'b1;
        repeat (DEPTH + 5) @(negedge clk);
        @(posedge clk);
        #1;
        issue(DIV, 44, 32'd50, 32'd5, 32'd10);
        drain();
`endif

        @(negedge clk);
        chk("final_idle", 64'(res_vld), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
